branch_predictor: RTL and testbench
===================================

# branch_predictor

Dynamic branch predictor and misprediction resolver paired with the fetch stage. Each cycle it looks up the current fetch PC in a direct-mapped branch target buffer (BTB) with 2-bit saturating counters and drives `prediction`/`control_pc` to fetch. On the resolve side it takes branch outcomes from EX/MEM, updates its tables, and raises `flush`/`pc_branch` when the earlier prediction was wrong. It also keeps branch and mispredict statistics counters.

## Interface
- `ENTRIES`, 16: BTB/counter entries; power of two, ≥2
- `IDX_W`, $clog2(ENTRIES): index width
- `clk`  in  1: clock
- `rst`  in  1: reset, asynchronous, active-high
- `if_pc`  in  32: current fetch PC
- `prediction`  out  1: predict taken for `if_pc`
- `control_pc`  out  32: predicted target (BTB target on hit, else `if_pc+4`)
- `ex_valid`  in  1: resolved instruction present this cycle
- `ex_is_branch`  in  1: resolved instruction is a conditional branch or jump
- `ex_pc`  in  32: PC of resolved instruction
- `ex_taken`  in  1: actual outcome
- `ex_target`  in  32: actual taken target
- `ex_pred`  in  1: `prediction` that was issued for this instruction, piped down
- `ex_pred_target`  in  32: `control_pc` that was issued, piped down
- `flush`  out  1: misprediction; fetch must redirect
- `pc_branch`  out  32: correct next PC when `flush`
- `br_cnt`  out  32: resolved branches since reset
- `miss_cnt`  out  32: mispredictions since reset

## Operation
- Index is `pc[IDX_W+1:2]`. Tag is `pc[31:IDX_W+2]`. Entry state: `valid`, `tag`, `target[31:0]`, `ctr[1:0]`.
- Lookup (combinational on `if_pc`): `hit = valid[idx] & tag==tag[idx]`. `prediction = hit & ctr[idx][1]`. `control_pc = hit ? target[idx] : if_pc+4` (32-bit wrap).
- Resolve (combinational): `fall = ex_pc+4`.
  - Branch case: when `ex_valid & ex_is_branch`, `flush = (ex_taken != ex_pred) | (ex_taken & ex_pred & ex_target != ex_pred_target)`.
  - Alias case: when `ex_valid & !ex_is_branch`, `flush = ex_pred`. This is a BTB hit on a non-branch.
  - In all other cases `flush = 0`.
  - `pc_branch = (ex_is_branch & ex_taken) ? ex_target : fall`.
- Update (on posedge `clk`, when `ex_valid`):
  - Branch, entry hit: the counter saturates up if taken, down if not (00↔01↔10↔11, no wrap). The target is written only if taken.
  - Branch, entry miss: allocate the entry by setting valid, tag and target (target = `ex_target` if taken, else unchanged). Initialise `ctr` to 10 if taken, 01 if not.
  - Non-branch whose tag hits: clear `valid`.
  - `br_cnt` increments on every resolved branch. `miss_cnt` increments when `flush`. Both wrap modulo 2^32.
- The fetch stage gives `flush` priority over `prediction`. This block does not gate `prediction` with `flush`.

## Timing
- Lookup and resolve outputs are zero-latency combinational. Table and counter updates become visible the cycle after the update edge.
- When lookup and update hit the same index in the same cycle, the lookup returns the pre-update state (read-before-write).
- Fetch stalls (NOP/halt) do not affect this block. Updates follow `ex_valid` only, and EX must drop `ex_valid` for squashed or bubble slots.
- On reset: all `valid` = 0, `ctr` = 01, targets and tags = 0, `br_cnt` = `miss_cnt` = 0.
  - `prediction` = 0 and `control_pc` = `if_pc+4` immediately.
  - `flush` and `pc_branch` follow their inputs. `flush` = 0 while `ex_valid` = 0.
- Reset asserted mid-update: the reset wins and no write occurs.

## Structure
- Shared package holds the following, so the fetch stage and EX agree:
  - the PC width constant (32) and instruction step (4);
  - the counter encodings `SNT`=00, `WNT`=01, `WT`=10, `ST`=11;
  - the BTB entry struct (valid/tag/target/ctr).
- One sub-module, `sat_counter2`: 2-bit saturating next-state function. It is instantiated in the update path, not per entry.
- Tables are flat register arrays with async reset, not inferred RAM.

## Test plan
- After reset, `if_pc`=0x100 → `prediction`=0, `control_pc`=0x104. Counters read 0.
- Resolve a branch at 0x40 with `ex_taken`=1, `ex_target`=0x80, `ex_pred`=0 → `flush`=1, `pc_branch`=0x80, `miss_cnt`=1. The next cycle `if_pc`=0x40 gives `prediction`=1, `control_pc`=0x80.
- The same branch resolved not-taken twice with `ex_pred` matching the prediction → counter goes 10→01→00. `prediction` drops to 0 after the first update. `flush` is asserted only on the first resolve.
- Predicted taken to 0x80 but actual target 0x90 → `flush`=1, `pc_branch`=0x90. The BTB target becomes 0x90.
- Non-branch at 0x40 with `ex_pred`=1 → `flush`=1, `pc_branch`=0x44. The entry is invalidated and the next lookup of 0x40 misses.
- Aliasing check (ENTRIES=16): the PCs 0x40 and 0x80 share an index with different tags. The lookup of 0x80 misses while 0x40 is allocated. Simultaneous lookup and update of 0x40 returns the old counter.

Source files
------------

// File: rtl/branch_predictor_pkg.sv
// Shared fetch/EX definitions for the branch predictor:
// PC geometry, 2-bit counter encodings and the BTB entry layout.
package branch_predictor_pkg;

    localparam int          PC_W      = 32;
    localparam logic [31:0] INSN_STEP = 32'd4;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } ctr_t;

    typedef struct packed {
        logic            valid;
        logic [PC_W-1:0] tag;
        logic [PC_W-1:0] target;
        ctr_t            ctr;
    } btb_entry_t;

endpackage

// File: rtl/branch_predictor_sat_counter2.sv
// 2-bit saturating counter next-state function, shared by
// every BTB entry through the single update port.
module sat_counter2
    import branch_predictor_pkg::*;
(
    input  logic [1:0] i_ctr,
    input  logic       i_taken,
    output logic [1:0] o_next
);

    always_comb begin
        o_next = i_ctr;
        if (i_taken) begin
            if (i_ctr != ST)
                o_next = i_ctr + 2'd1;
        end else if (i_ctr != SNT) begin
            o_next = i_ctr - 2'd1;
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit counters: combinational lookup
// for fetch, misprediction resolve and table update from EX.
module branch_predictor
    import branch_predictor_pkg::*;
#(
    parameter int ENTRIES = 16,
    parameter int IDX_W   = $clog2(ENTRIES)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] i_if_pc,
    output logic        o_prediction,
    output logic [31:0] o_control_pc,
    input  logic        i_ex_valid,
    input  logic        i_ex_is_branch,
    input  logic [31:0] i_ex_pc,
    input  logic        i_ex_taken,
    input  logic [31:0] i_ex_target,
    input  logic        i_ex_pred,
    input  logic [31:0] i_ex_pred_target,
    output logic        o_flush,
    output logic [31:0] o_pc_branch,
    output logic [31:0] o_br_cnt,
    output logic [31:0] o_miss_cnt
);

    btb_entry_t  r_btb [ENTRIES];
    logic [31:0] r_br_cnt;
    logic [31:0] r_miss_cnt;

    logic [IDX_W-1:0] w_if_idx;
    logic [IDX_W-1:0] w_ex_idx;
    logic [31:0]      w_if_tag;
    logic [31:0]      w_ex_tag;
    logic             w_if_hit;
    logic             w_ex_hit;
    logic [1:0]       w_ctr_next;

    assign w_if_idx = i_if_pc[IDX_W+1:2];
    assign w_ex_idx = i_ex_pc[IDX_W+1:2];
    assign w_if_tag = i_if_pc >> (IDX_W + 2);
    assign w_ex_tag = i_ex_pc >> (IDX_W + 2);

    assign w_if_hit = r_btb[w_if_idx].valid &&
                      (r_btb[w_if_idx].tag == w_if_tag);
    assign w_ex_hit = r_btb[w_ex_idx].valid &&
                      (r_btb[w_ex_idx].tag == w_ex_tag);

    assign o_prediction = w_if_hit & r_btb[w_if_idx].ctr[1];
    assign o_control_pc = w_if_hit ? r_btb[w_if_idx].target
                                   : i_if_pc + INSN_STEP;

    always_comb begin
        o_flush = 1'b0;
        if (i_ex_valid && i_ex_is_branch)
            o_flush = (i_ex_taken != i_ex_pred) |
                      (i_ex_taken & i_ex_pred &
                       (i_ex_target != i_ex_pred_target));
        else if (i_ex_valid)
            o_flush = i_ex_pred;
    end

    assign o_pc_branch = (i_ex_is_branch && i_ex_taken)
                       ? i_ex_target : i_ex_pc + INSN_STEP;

    sat_counter2 u_sat (
        .i_ctr   (r_btb[w_ex_idx].ctr),
        .i_taken (i_ex_taken),
        .o_next  (w_ctr_next)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < ENTRIES; k++) begin
                r_btb[k].valid  <= 1'b0;
                r_btb[k].tag    <= '0;
                r_btb[k].target <= '0;
                r_btb[k].ctr    <= WNT;
            end
            r_br_cnt   <= '0;
            r_miss_cnt <= '0;
        end else begin
            if (i_ex_valid && i_ex_is_branch) begin
                r_br_cnt <= r_br_cnt + 32'd1;
                if (w_ex_hit) begin
                    r_btb[w_ex_idx].ctr <= ctr_t'(w_ctr_next);
                end else begin
                    r_btb[w_ex_idx].valid <= 1'b1;
                    r_btb[w_ex_idx].tag   <= w_ex_tag;
                    r_btb[w_ex_idx].ctr   <= i_ex_taken ? WT : WNT;
                end
                if (i_ex_taken)
                    r_btb[w_ex_idx].target <= i_ex_target;
            end else if (i_ex_valid && w_ex_hit) begin
                // A hit on a non-branch is an alias; drop the entry
                r_btb[w_ex_idx].valid <= 1'b0;
            end
            if (o_flush)
                r_miss_cnt <= r_miss_cnt + 32'd1;
        end
    end

    assign o_br_cnt   = r_br_cnt;
    assign o_miss_cnt = r_miss_cnt;

endmodule

// File: tb/tb_branch_predictor.sv
// Directed and random checks of branch_predictor against a
// table-level reference model.
module tb_branch_predictor;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] if_pc;
    logic        prediction;
    logic [31:0] control_pc;
    logic        ex_valid;
    logic        ex_is_branch;
    logic [31:0] ex_pc;
    logic        ex_taken;
    logic [31:0] ex_target;
    logic        ex_pred;
    logic [31:0] ex_pred_target;
    logic        flush;
    logic [31:0] pc_branch;
    logic [31:0] br_cnt;
    logic [31:0] miss_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    bit          m_valid [16];
    logic [31:0] m_tag   [16];
    logic [31:0] m_tgt   [16];
    int          m_ctr   [16];
    logic [31:0] m_br;
    logic [31:0] m_miss;

    always #5 clk = ~clk;

    branch_predictor dut (
        .clk              (clk),
        .rst              (rst),
        .i_if_pc          (if_pc),
        .o_prediction     (prediction),
        .o_control_pc     (control_pc),
        .i_ex_valid       (ex_valid),
        .i_ex_is_branch   (ex_is_branch),
        .i_ex_pc          (ex_pc),
        .i_ex_taken       (ex_taken),
        .i_ex_target      (ex_target),
        .i_ex_pred        (ex_pred),
        .i_ex_pred_target (ex_pred_target),
        .o_flush          (flush),
        .o_pc_branch      (pc_branch),
        .o_br_cnt         (br_cnt),
        .o_miss_cnt       (miss_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int m_idx(input logic [31:0] pc);
        return int'((pc / 4) % 16);
    endfunction

    function automatic bit m_hit(input logic [31:0] pc);
        int i = m_idx(pc);
        return m_valid[i] && (m_tag[i] == pc / 64);
    endfunction

    function automatic bit m_pred(input logic [31:0] pc);
        return m_hit(pc) && (m_ctr[m_idx(pc)] >= 2);
    endfunction

    function automatic logic [31:0] m_cpc(input logic [31:0] pc);
        return m_hit(pc) ? m_tgt[m_idx(pc)] : pc + 32'd4;
    endfunction

    function automatic bit m_flush();
        if (!ex_valid) return 1'b0;
        if (!ex_is_branch) return ex_pred;
        if (ex_taken != ex_pred) return 1'b1;
        return ex_taken && (ex_target != ex_pred_target);
    endfunction

    task automatic m_reset();
        for (int i = 0; i < 16; i++) begin
            m_valid[i] = 1'b0;
            m_tag[i]   = '0;
            m_tgt[i]   = '0;
            m_ctr[i]   = 1;
        end
        m_br   = '0;
        m_miss = '0;
    endtask

    task automatic m_update(input bit fl);
        int i = m_idx(ex_pc);
        bit h = m_hit(ex_pc);
        if (fl) m_miss = m_miss + 1;
        if (!ex_valid) return;
        if (ex_is_branch) begin
            m_br = m_br + 1;
            if (h) begin
                if (ex_taken) m_ctr[i] = (m_ctr[i] == 3) ? 3 : m_ctr[i] + 1;
                else          m_ctr[i] = (m_ctr[i] == 0) ? 0 : m_ctr[i] - 1;
            end else begin
                m_valid[i] = 1'b1;
                m_tag[i]   = ex_pc / 64;
                m_ctr[i]   = ex_taken ? 2 : 1;
            end
            if (ex_taken) m_tgt[i] = ex_target;
        end else if (h) begin
            m_valid[i] = 1'b0;
        end
    endtask

    task automatic drive(input logic [31:0] ipc, input bit ev,
                         input bit br, input logic [31:0] epc,
                         input bit tk, input logic [31:0] tgt,
                         input bit pr, input logic [31:0] prt);
        if_pc = ipc; ex_valid = ev; ex_is_branch = br; ex_pc = epc;
        ex_taken = tk; ex_target = tgt; ex_pred = pr;
        ex_pred_target = prt;
    endtask

    // Model-checked clock cycle; starts and ends just after negedge.
    task automatic cycle();
        bit          fl;
        logic [31:0] pb;
        #1;
        fl = m_flush();
        pb = (ex_is_branch && ex_taken) ? ex_target : ex_pc + 32'd4;
        chk("prediction", 32'(prediction), 32'(m_pred(if_pc)));
        chk("control_pc", control_pc, m_cpc(if_pc));
        chk("flush", 32'(flush), 32'(fl));
        chk("pc_branch", pc_branch, pb);
        @(posedge clk);
        m_update(fl);
        #1;
        chk("br_cnt", br_cnt, m_br);
        chk("miss_cnt", miss_cnt, m_miss);
        @(negedge clk);
    endtask

    initial begin
        logic [31:0] p;
        m_reset();
        rst = 1'b1;
        drive(32'h100, 0, 0, 0, 0, 0, 0, 0);
        #1;
        chk("rst_pred", 32'(prediction), 32'd0);
        chk("rst_cpc", control_pc, 32'h104);
        chk("rst_br", br_cnt, 32'd0);
        chk("rst_miss", miss_cnt, 32'd0);
        chk("rst_flush", 32'(flush), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        drive(32'h100, 1, 1, 32'h40, 1, 32'h80, 0, 32'h44);
        #1;
        chk("alloc_flush", 32'(flush), 32'd1);
        chk("alloc_pcb", pc_branch, 32'h80);
        cycle();
        chk("alloc_miss", miss_cnt, 32'd1);

        drive(32'h40, 0, 0, 0, 0, 0, 0, 0);
        #1;
        chk("hit_pred", 32'(prediction), 32'd1);
        chk("hit_cpc", control_pc, 32'h80);
        cycle();

        drive(32'h80, 0, 0, 0, 0, 0, 0, 0);
        #1;
        chk("alias_pred", 32'(prediction), 32'd0);
        chk("alias_cpc", control_pc, 32'h84);
        cycle();

        drive(32'h40, 1, 1, 32'h40, 0, 32'h80, 1, 32'h80);
        #1;
        chk("nt1_flush", 32'(flush), 32'd1);
        chk("nt1_pcb", pc_branch, 32'h44);
        cycle();
        drive(32'h40, 1, 1, 32'h40, 0, 32'h80, 0, 32'h44);
        #1;
        chk("nt2_pred", 32'(prediction), 32'd0);
        chk("nt2_flush", 32'(flush), 32'd0);
        cycle();

        drive(32'h40, 1, 1, 32'h40, 1, 32'h90, 1, 32'h80);
        #1;
        chk("tgt_flush", 32'(flush), 32'd1);
        chk("tgt_pcb", pc_branch, 32'h90);
        cycle();
        drive(32'h40, 0, 0, 0, 0, 0, 0, 0);
        #1;
        chk("tgt_cpc", control_pc, 32'h90);
        chk("tgt_pred", 32'(prediction), 32'd0);
        cycle();

        drive(32'h40, 1, 1, 32'h40, 1, 32'h90, 0, 32'h44);
        #1;
        chk("rbw_pred", 32'(prediction), 32'd0);
        cycle();
        drive(32'h40, 0, 0, 0, 0, 0, 0, 0);
        #1;
        chk("rbw_after", 32'(prediction), 32'd1);
        cycle();

        drive(32'h40, 1, 0, 32'h40, 0, 32'h0, 1, 32'h90);
        #1;
        chk("nb_flush", 32'(flush), 32'd1);
        chk("nb_pcb", pc_branch, 32'h44);
        cycle();
        drive(32'h40, 0, 0, 0, 0, 0, 0, 0);
        #1;
        chk("nb_cpc", control_pc, 32'h44);
        cycle();

        for (int n = 0; n < 400; n++) begin
            logic [31:0] ip, ep, et, pt;
            bit pr;
            ip = ($urandom_range(0, 3) << 6) | ($urandom_range(0, 15) << 2);
            ep = ($urandom_range(0, 3) << 6) | ($urandom_range(0, 15) << 2);
            if ($urandom_range(0, 3) == 0) ip = ep;
            et = {$urandom_range(0, 255), 2'b00};
            if ($urandom_range(0, 1) == 1) begin
                pr = m_pred(ep);
                pt = m_cpc(ep);
            end else begin
                pr = 1'($urandom);
                pt = ($urandom_range(0, 1) == 1) ? et : ep + 32'd4;
            end
            drive(ip, ($urandom_range(0, 4) != 0), ($urandom_range(0, 4) != 0),
                  ep, 1'($urandom), et, pr, pt);
            cycle();
        end

        p = 32'h40;
        drive(p, 1, 1, p, 1, 32'h80, 0, 32'h44);
        rst = 1'b1;
        @(posedge clk);
        #1;
        m_reset();
        chk("mid_rst_pred", 32'(prediction), 32'd0);
        chk("mid_rst_cpc", control_pc, 32'h44);
        chk("mid_rst_br", br_cnt, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        drive(p, 0, 0, 0, 0, 0, 0, 0);
        cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
